// File: rtl/seq_detector_p.sv
// Runtime-programmable sequence detector over a stream of SYM_W-bit symbols.
// Matches the newest len accepted symbols against a stored pattern; registered match pulse and saturating counter.
module seq_detector_p #(
  parameter int unsigned SYM_W       = 2,
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEF_LEN     = 3,
  parameter logic [MAX_LEN*SYM_W-1:0] DEF_PATTERN = 16'h0039,
  parameter bit          DEF_OVERLAP = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [SYM_W-1:0]         sym,
  input  logic                     cfg_we,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic [MAX_LEN*SYM_W-1:0] cfg_pattern,
  input  logic                     cfg_overlap,
  input  logic                     cnt_clr,
  output logic                     match,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [LEN_W-1:0]         fill
);

  localparam int PAT_W = MAX_LEN * SYM_W;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [SYM_W-1:0] hist [MAX_LEN];
  logic [SYM_W-1:0] win  [MAX_LEN];
  logic [LEN_W-1:0] len_q;
  logic [PAT_W-1:0] pattern_q;
  logic             overlap_q;
  logic [LEN_W-1:0] len_clamped;
  logic             enough;
  logic             all_eq;
  logic             hit;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    len_clamped = cfg_len;
    if (cfg_len == '0)
      len_clamped = LEN_W'(1);
    else if (cfg_len > MAX_LEN_L)
      len_clamped = MAX_LEN_L;
  end

  // Window seen by the comparator: the incoming symbol is the newest entry.
  always_comb begin
    win[0] = sym;
    for (int k = 1; k < int'(MAX_LEN); k++)
      win[k] = hist[k-1];
  end

  always_comb begin
    enough = (int'(fill) + 1 >= int'(len_q));
    all_eq = 1'b1;
    for (int j = 0; j < int'(MAX_LEN); j++) begin
      if (j < int'(len_q)) begin
        if (win[j] != pattern_q[(int'(len_q) - 1 - j) * SYM_W +: SYM_W])
          all_eq = 1'b0;
      end
    end
    hit = in_valid && enough && all_eq;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      // NOTE: history is cleared explicitly; the fill guard already hides stale entries, but a known state eases debug.
      for (int k = 0; k < int'(MAX_LEN); k++)
        hist[k] <= '0;
      fill      <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
      len_q     <= LEN_W'(DEF_LEN);
      pattern_q <= DEF_PATTERN;
      overlap_q <= DEF_OVERLAP;
    end else if (cfg_we) begin
      for (int k = 0; k < int'(MAX_LEN); k++)
        hist[k] <= '0;
      fill      <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
      len_q     <= len_clamped;
      pattern_q <= cfg_pattern;
      overlap_q <= cfg_overlap;
    end else begin
      match <= hit;
      if (in_valid) begin
        for (int k = int'(MAX_LEN) - 1; k > 0; k--)
          hist[k] <= hist[k-1];
        hist[0] <= sym;
        // A non-overlapping hit restarts the window so earlier symbols cannot be reused.
        if (hit && !overlap_q)
          fill <= '0;
        else if (fill < MAX_LEN_L)
          fill <= fill + 1'b1;
      end
      if (cnt_clr)
        match_cnt <= '0;
      else if (hit && (match_cnt != {CNT_W{1'b1}}))
        match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detector_p.sv
// Directed self-checking bench for seq_detector_p; a second instance with CNT_W=2 covers counter saturation.
module tb_seq_detector_p;

  localparam int SYM_W   = 2;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int PAT_W   = MAX_LEN * SYM_W;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic [SYM_W-1:0] sym = '0;
  logic             cfg_we = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic             cfg_overlap = 1'b0;
  logic             cnt_clr = 1'b0;

  logic             match, match2;
  logic [7:0]       match_cnt;
  logic [1:0]       match_cnt2;
  logic [LEN_W-1:0] fill, fill2;

  int tests_run = 0;
  int tests_failed = 0;

  seq_detector_p u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sym(sym),
    .cfg_we(cfg_we), .cfg_len(cfg_len), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .match(match), .match_cnt(match_cnt), .fill(fill)
  );

  seq_detector_p #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sym(sym),
    .cfg_we(cfg_we), .cfg_len(cfg_len), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .match(match2), .match_cnt(match_cnt2), .fill(fill2)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [SYM_W-1:0] s);
    in_valid = 1'b1;
    sym      = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic configure(input logic [LEN_W-1:0] l, input logic [PAT_W-1:0] p, input logic ov);
    cfg_we      = 1'b1;
    cfg_len     = l;
    cfg_pattern = p;
    cfg_overlap = ov;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  // Reset state, and reset taking priority over a simultaneous configuration write.
  task automatic test_reset();
    reset = 1'b1; cfg_we = 1'b1; cfg_len = 4'd1; cfg_pattern = 16'h0000; in_valid = 1'b1; sym = 2'd0;
    @(posedge clk);
    #1;
    reset = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (match !== 1'b0 || match_cnt !== 8'd0 || fill !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_state: match=%0b cnt=%0d fill=%0d expected 0/0/0", match, match_cnt, fill);
    end
    send(2'd1); send(2'd2); send(2'd3);
    tests_run++;
    if (match !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_default_cfg: match=%0b expected 1", match);
    end
  endtask

  task automatic test_default_stream();
    logic [SYM_W-1:0] s [16] = '{1,1,2,1,2,1,3,1,2,3,1,2,1,2,3,1};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send(s[i]);
      tests_run++;
      if (match !== ((i == 9) || (i == 14))) begin
        tests_failed++;
        $display("FAIL default_stream[%0d]: match=%0b expected %0b", i, match, (i == 9) || (i == 14));
      end
    end
    tests_run++;
    if (match_cnt !== 8'd2 || fill !== 4'd8) begin
      tests_failed++;
      $display("FAIL default_stream_end: cnt=%0d fill=%0d expected 2/8", match_cnt, fill);
    end
  endtask

  task automatic test_overlap();
    logic [SYM_W-1:0] s [5] = '{1,2,1,2,1};
    configure(4'd3, 16'h0019, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send(s[i]);
      tests_run++;
      if (match !== ((i == 2) || (i == 4))) begin
        tests_failed++;
        $display("FAIL overlap_on[%0d]: match=%0b expected %0b", i, match, (i == 2) || (i == 4));
      end
    end
    tests_run++;
    if (match_cnt !== 8'd2) begin
      tests_failed++;
      $display("FAIL overlap_on_cnt: cnt=%0d expected 2", match_cnt);
    end
    configure(4'd3, 16'h0019, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send(s[i]);
      tests_run++;
      if (match !== (i == 2)) begin
        tests_failed++;
        $display("FAIL overlap_off[%0d]: match=%0b expected %0b", i, match, i == 2);
      end
    end
    tests_run++;
    if (match_cnt !== 8'd1 || fill !== 4'd2) begin
      tests_failed++;
      $display("FAIL overlap_off_end: cnt=%0d fill=%0d expected 1/2", match_cnt, fill);
    end
  endtask

  task automatic test_bubbles();
    configure(4'd3, 16'h0039, 1'b1);
    send(2'd1);
    for (int i = 0; i < 3; i++) begin
      idle();
      tests_run++;
      if (match !== 1'b0) begin
        tests_failed++;
        $display("FAIL bubble_low[%0d]: match=%0b expected 0", i, match);
      end
    end
    send(2'd2);
    idle();
    send(2'd3);
    tests_run++;
    if (match !== 1'b1 || fill !== 4'd3) begin
      tests_failed++;
      $display("FAIL bubble_match: match=%0b fill=%0d expected 1/3", match, fill);
    end
    idle();
    tests_run++;
    if (match !== 1'b0 || match_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL bubble_pulse: match=%0b cnt=%0d expected 0/1", match, match_cnt);
    end
  endtask

  task automatic test_reset_mid();
    configure(4'd3, 16'h0039, 1'b1);
    send(2'd1); send(2'd2);
    do_reset();
    send(2'd3);
    tests_run++;
    if (match !== 1'b0 || fill !== 4'd1 || match_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: match=%0b fill=%0d cnt=%0d expected 0/1/0", match, fill, match_cnt);
    end
    send(2'd1); send(2'd2);
    cfg_we = 1'b1; cfg_len = 4'd3; cfg_pattern = 16'h0039; cfg_overlap = 1'b1;
    in_valid = 1'b1; sym = 2'd3;
    @(posedge clk);
    #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (match !== 1'b0 || fill !== 4'd0) begin
      tests_failed++;
      $display("FAIL cfg_drops_sym: match=%0b fill=%0d expected 0/0", match, fill);
    end
  endtask

  task automatic test_len_clamp();
    logic [SYM_W-1:0] s [3] = '{2,0,2};
    configure(4'd0, 16'h0002, 1'b1);
    for (int i = 0; i < 3; i++) begin
      send(s[i]);
      tests_run++;
      if (match !== (i != 1)) begin
        tests_failed++;
        $display("FAIL len_min[%0d]: match=%0b expected %0b", i, match, i != 1);
      end
    end
    tests_run++;
    if (match_cnt !== 8'd2) begin
      tests_failed++;
      $display("FAIL len_min_cnt: cnt=%0d expected 2", match_cnt);
    end
    configure(4'd15, 16'hFFFF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(2'd3);
      tests_run++;
      if (match !== (i == 7)) begin
        tests_failed++;
        $display("FAIL len_max[%0d]: match=%0b expected %0b", i, match, i == 7);
      end
    end
    tests_run++;
    if (fill !== 4'd8 || match_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL len_max_end: fill=%0d cnt=%0d expected 8/1", fill, match_cnt);
    end
  endtask

  task automatic test_cnt_sat();
    logic [1:0] exp_cnt [5] = '{1,2,3,3,3};
    configure(4'd1, 16'h0001, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send(2'd1);
      tests_run++;
      if (match_cnt2 !== exp_cnt[i] || match2 !== 1'b1) begin
        tests_failed++;
        $display("FAIL cnt_sat[%0d]: cnt=%0d match=%0b expected %0d/1", i, match_cnt2, match2, exp_cnt[i]);
      end
    end
    cnt_clr = 1'b1;
    send(2'd1);
    cnt_clr = 1'b0;
    tests_run++;
    if (match_cnt2 !== 2'd0 || match2 !== 1'b1 || match_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL cnt_clr_hit: cnt2=%0d match2=%0b cnt=%0d expected 0/1/0", match_cnt2, match2, match_cnt);
    end
    send(2'd1);
    tests_run++;
    if (match_cnt2 !== 2'd1 || match_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL cnt_resume: cnt2=%0d cnt=%0d expected 1/1", match_cnt2, match_cnt);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_default_stream();
    test_overlap();
    test_bubbles();
    test_reset_mid();
    test_len_clamp();
    test_cnt_sat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_detector_p.md
Name: seq_detector_p

Overview:
Parametrised, runtime-programmable sequence detector for a stream of SYM_W-bit symbols. It compares the most recent cfg_len accepted symbols against a stored pattern and emits a one-cycle registered match pulse. It also keeps a saturating match counter and supports overlapping and non-overlapping detection. It replaces fixed 2-bit, fixed-pattern detectors in datapath test and monitor logic.

Parameters:
SYM_W, 2, symbol width in bits
MAX_LEN, 8, maximum pattern length in symbols (history depth)
LEN_W, 4, width of length fields; must hold MAX_LEN
CNT_W, 8, match counter width
DEF_LEN, 3, pattern length after reset
DEF_PATTERN, 16'h0039, pattern after reset (MAX_LEN*SYM_W bits); encodes the sequence 1,2,3
DEF_OVERLAP, 1, overlap mode after reset

Ports:
clk  input  1  rising-edge clock, the only clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  symbol on sym is accepted at this edge
sym  input  SYM_W  input symbol
cfg_we  input  1  load cfg_len, cfg_pattern and cfg_overlap; clears history and counter
cfg_len  input  LEN_W  pattern length in symbols
cfg_pattern  input  MAX_LEN*SYM_W  pattern; symbol k at bits [k*SYM_W +: SYM_W], k=0 is the first symbol of the sequence
cfg_overlap  input  1  1 = overlapping matches allowed
cnt_clr  input  1  clear match_cnt only
match  output  1  registered one-cycle match pulse
match_cnt  output  CNT_W  saturating count of matches
fill  output  LEN_W  number of valid symbols in history, saturates at MAX_LEN

Behaviour:
- Reset (at edge with reset=1):
  - match=0, match_cnt=0, fill=0, history cleared.
  - len=DEF_LEN, pattern=DEF_PATTERN, overlap=DEF_OVERLAP.
  - reset overrides all other inputs.
- Priority at each edge: reset > cfg_we > in_valid.
- cfg_we=1:
  - Stores the configuration; fill=0; match_cnt=0; match=0.
  - Any in_valid symbol in the same cycle is dropped.
- Length rules:
  - Stored len = cfg_len clamped to the range 1..MAX_LEN.
  - cfg_len=0 stores 1; cfg_len>MAX_LEN stores MAX_LEN.
- Accepting a symbol (in_valid=1, no reset, no cfg_we):
  - sym is shifted into history (newest at index 0); the oldest symbol is discarded once MAX_LEN symbols are held.
  - hit (combinational) = (fill+1 >= len) AND, for every j in 0..len-1, the j-th newest symbol including sym equals pattern[len-1-j].
  - Next match = hit.
  - If hit and overlap=0, next fill=0, so the window restarts and symbols before the match cannot contribute.
  - Otherwise next fill=min(fill+1, MAX_LEN).
- Latency: match is high for exactly the one cycle following the edge that accepted the completing symbol.
- in_valid=0 edges:
  - match=0.
  - history and fill are held, so bubbles do not break a sequence.
- match_cnt:
  - Increments by 1 at each edge where hit is true.
  - Saturates at 2^CNT_W-1; there is no wrap-around.
  - cnt_clr=1 clears it to 0. If a hit occurs in the same cycle, the result is 0 and the hit is not counted; match still pulses.
- Reconfiguration mid-sequence: partial progress is always discarded.
- The pattern comparison is purely combinational from registered state plus sym, with no multi-cycle paths.

Test Plan:
- Default config. Stream 1,1,2,1,2,1,3,1,2,3,1,2,1,2,3,1 with in_valid=1 every cycle -> match pulses the cycle after symbols #9 and #14 (0-based); final match_cnt=2.
- cfg_pattern=1,2,1, len=3, overlap=1. Stream 1,2,1,2,1 -> matches after #2 and #4, cnt=2. Same stream with overlap=0 -> single match after #2, cnt=1, fill=2 at end.
- Default config. Stream 1,(bubble x3),2,(bubble),3 -> one match after the 3; match stays low during bubbles; fill=3.
- Feed 1,2 then assert reset for one cycle, then feed 3 -> no match; fill=1; cnt=0. Separately, cfg_we asserted in the same cycle as sym=3 completing 1,2,3 -> no match, fill=0.
- cfg_len=0 with pattern[0]=2, stream 2,0,2 -> two matches (len clamped to 1). cfg_len=15 -> len=MAX_LEN; eight identical symbols matching the pattern -> exactly one match after the 8th, none before.
- CNT_W=2, len=1 pattern 1, stream of 5 ones -> cnt=1,2,3,3,3. cnt_clr in the same cycle as a hit -> cnt=0 with match=1.
